// File: rtl/ff_bist_if.sv
// ff_bist_if: the signals between the flip-flop BIST controller and the
// logic around it.
//   start    run request into the controller
//   d_out    stimulus bit driven to the flip-flop D input
//   q_in     flip-flop Q output sampled by the controller
//   busy     controller is in RUN or DRAIN
//   done     controller is in DONE
//   pass     DONE with no mismatches
//   err_cnt  mismatch count, saturating at 255
//   vec_cnt  vectors issued in the current or last run
// modport master: the controller side. modport slave: the environment side.
interface ff_bist_if;
  logic        start;
  logic        d_out;
  logic        q_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_cnt;
  logic [15:0] vec_cnt;

  modport master (
    input  start, q_in,
    output d_out, busy, done, pass, err_cnt, vec_cnt
  );

  modport slave (
    output start, q_in,
    input  d_out, busy, done, pass, err_cnt, vec_cnt
  );
endinterface

// File: rtl/ff_bist.sv
// ff_bist: built-in self-test driver/checker for a single-bit D flip-flop.
// An 8-bit LFSR (x^8+x^6+x^5+x^4+1) produces one stimulus bit per RUN cycle.
// Each issued bit also enters a LAT-deep expected pipe. When the oldest pipe
// stage is valid, it is compared against the sampled Q. Mismatches are
// counted with saturation at 255.
// Parameters:
//   N_VEC  vectors per run (1..65535)
//   SEED   non-zero LFSR load value
//   LAT    flip-flop latency in cycles (1..4)
// Ports:
//   clk    sole clock, rising edge
//   rst    asynchronous active-high reset
//   bus    ff_bist_if.master (start, q_in in; d_out, busy, done, pass,
//          err_cnt, vec_cnt out)
module ff_bist #(
  parameter int         N_VEC = 16,
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int         LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  ff_bist_if.master     bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       lfsr;
  logic [15:0]      vec_cnt;
  logic [7:0]       err_cnt;
  logic [2:0]       drain_cnt;
  logic [LAT-1:0]   pipe_vld;
  logic [LAT-1:0]   pipe_bit;
  logic             launch;
  logic             last_vec;
  logic             drain_end;
  logic             shift;
  logic             mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // vec_cnt still holds the count before the current edge, so N_VEC-1 marks
  // the edge that issues the final vector.
  assign last_vec  = (vec_cnt == 16'(N_VEC - 1));
  assign drain_end = (drain_cnt == 3'(LAT - 1));
  assign shift     = (state == S_RUN) || (state == S_DRAIN);
  assign mismatch  = pipe_vld[LAT-1] && (bus.q_in != pipe_bit[LAT-1]);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nxt = S_RUN;
          launch    = 1'b1;
        end
      end
      S_RUN:   if (last_vec)  state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      drain_cnt <= '0;
      pipe_vld  <= '0;
      pipe_bit  <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        lfsr      <= SEED;
        vec_cnt   <= '0;
        err_cnt   <= '0;
        drain_cnt <= '0;
        pipe_vld  <= '0;
      end else begin
        if (state == S_RUN) begin
          lfsr    <= lfsr_step(lfsr);
          vec_cnt <= vec_cnt + 16'd1;
        end
        // Shift towards the MSB; only RUN inserts valid expected bits.
        if (shift) begin
          pipe_vld <= LAT'({pipe_vld, state == S_RUN});
          pipe_bit <= LAT'({pipe_bit, lfsr[0]});
        end
        if (state == S_DRAIN) drain_cnt <= drain_cnt + 3'd1;
        if (mismatch) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  assign bus.d_out   = (state == S_RUN) & lfsr[0];
  assign bus.busy    = shift;
  assign bus.done    = (state == S_DONE);
  assign bus.pass    = (state == S_DONE) && (err_cnt == 8'd0);
  assign bus.err_cnt = err_cnt;
  assign bus.vec_cnt = vec_cnt;

endmodule

// File: tb/tb_ff_bist.sv
// Testbench for ff_bist. Two controllers: one with N_VEC=16, one with
// N_VEC=300 for counter saturation. Each drives a behavioural flip-flop
// whose Q can be inverted per vector to inject mismatches. Expected run
// results go into a queue when a run starts; a monitor pops and compares
// them when DONE rises.
module tb_ff_bist;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int         LAT  = 1;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   start0 = 1'b0, start1 = 1'b0;
  logic   inj0 = 1'b0, inj1 = 1'b0;
  logic   q0 = 1'b0, q1 = 1'b0;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;

  typedef struct {
    int     err;
    int     pass;
    int     vec;
    longint done_cyc;
  } exp_t;

  exp_t q_exp0[$];
  exp_t q_exp1[$];
  bit   seq[0:300];

  ff_bist_if if0 ();
  ff_bist_if if1 ();

  assign if0.start = start0;
  assign if0.q_in  = q0;
  assign if1.start = start1;
  assign if1.q_in  = q1;

  ff_bist #(.N_VEC(16), .SEED(SEED), .LAT(LAT)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  ff_bist #(.N_VEC(300), .SEED(SEED), .LAT(LAT)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural flip-flops under test; inj flips the captured bit.
  always @(posedge clk) begin
    q0 <= if0.d_out ^ inj0;
    q1 <= if1.d_out ^ inj1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic dout(input int w);
    return (w != 0) ? if1.d_out : if0.d_out;
  endfunction
  function automatic logic busy(input int w);
    return (w != 0) ? if1.busy : if0.busy;
  endfunction
  function automatic logic done(input int w);
    return (w != 0) ? if1.done : if0.done;
  endfunction
  function automatic logic pass(input int w);
    return (w != 0) ? if1.pass : if0.pass;
  endfunction
  function automatic int errc(input int w);
    return (w != 0) ? int'(if1.err_cnt) : int'(if0.err_cnt);
  endfunction
  function automatic int vecc(input int w);
    return (w != 0) ? int'(if1.vec_cnt) : int'(if0.vec_cnt);
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w != 0) start1 = v; else start0 = v;
  endtask
  task automatic set_inj(input int w, input logic v);
    if (w != 0) inj1 = v; else inj0 = v;
  endtask

  // Reference stimulus: the LFSR as a polynomial recurrence over an integer.
  // Taps x^8,x^6,x^5,x^4 feed back from state bits 7,5,4,3 (mask 8'hB8).
  task automatic build_seq();
    int s;
    s = int'(SEED);
    for (int k = 0; k <= 300; k++) begin
      seq[k] = bit'(s % 2);
      s = ((s * 2) + int'(^(8'(s) & 8'hB8))) % 256;
    end
  endtask

  task automatic check_done(input int w);
    exp_t e;
    if ((w == 0 && q_exp0.size() == 0) || (w != 0 && q_exp1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done dut=%0d no run outstanding", w);
    end else begin
      e = (w != 0) ? q_exp1.pop_front() : q_exp0.pop_front();
      chk("done_cycle", cyc, e.done_cyc);
      chk("err_cnt", errc(w), e.err);
      chk("pass", pass(w), e.pass);
      chk("vec_cnt", vecc(w), e.vec);
      chk("busy_at_done", busy(w), 0);
    end
  endtask

  logic done_prev0 = 1'b0, done_prev1 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      done_prev0 <= 1'b0;
      done_prev1 <= 1'b0;
    end else begin
      if (if0.done && !done_prev0) check_done(0);
      if (if1.done && !done_prev1) check_done(1);
      done_prev0 <= if0.done;
      done_prev1 <= if1.done;
    end
  end

  task automatic check_reset_state(input int w);
    chk("rst_d_out", dout(w), 0);
    chk("rst_busy", busy(w), 0);
    chk("rst_done", done(w), 0);
    chk("rst_pass", pass(w), 0);
    chk("rst_err_cnt", errc(w), 0);
    chk("rst_vec_cnt", vecc(w), 0);
  endtask

  // mode: 0 ideal, 1 inverted, 2 random mismatches.
  // pulse_at: vector window in which START is pulsed mid-run (0 = none).
  // keep: leave START high at the end. abort_at: reset after this edge.
  task automatic run(input int w, input int mode, input int pulse_at,
                     input bit keep, input int abort_at);
    int   n;
    bit   injv[1:300];
    int   nerr;
    int   part;
    exp_t e;
    n = (w != 0) ? 300 : 16;
    nerr = 0;
    for (int k = 1; k <= n; k++) begin
      injv[k] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : bit'($urandom_range(0, 1));
      nerr += int'(injv[k]);
    end
    e.err  = (nerr > 255) ? 255 : nerr;
    e.pass = (nerr == 0) ? 1 : 0;
    e.vec  = n;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    e.done_cyc = cyc + n + LAT;
    if (abort_at == 0) begin
      if (w != 0) q_exp1.push_back(e); else q_exp0.push_back(e);
    end
    chk("busy_after_start", busy(w), 1);
    chk("done_after_start", done(w), 0);
    chk("err_after_start", errc(w), 0);
    if (!keep) set_start(w, 1'b0);
    for (int k = 1; k <= n; k++) begin
      if (abort_at != 0 && k == abort_at + 1) begin
        part = 0;
        for (int j = 1; j <= abort_at - LAT; j++) part += int'(injv[j]);
        chk("err_before_reset", errc(w), part);
        chk("vec_before_reset", vecc(w), abort_at);
        #2 rst = 1'b1;
        #1;
        check_reset_state(w);
        set_start(w, 1'b0);
        set_inj(w, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        return;
      end
      set_inj(w, injv[k]);
      chk("d_out", dout(w), seq[k-1]);
      if (pulse_at != 0) set_start(w, k == pulse_at);
      @(posedge clk); #1;
    end
    set_inj(w, 1'b0);
    if (pulse_at != 0) set_start(w, 1'b0);
    chk("d_out_drain", dout(w), 0);
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    build_seq();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b0;
    idle(2);

    // Ideal flip-flop, single START pulse.
    run(0, 0, 0, 1'b0, 0);
    idle(3);
    // Inverted flip-flop: every compare mismatches.
    run(0, 1, 0, 1'b0, 0);
    idle(3);
    // START during RUN must be ignored.
    run(0, 0, 5, 1'b0, 0);
    idle(3);
    // Reset mid-run, then a clean run.
    run(0, 1, 0, 1'b0, 8);
    idle(1);
    run(0, 0, 0, 1'b0, 0);
    idle(3);
    // Back-to-back runs with START held high.
    run(0, 0, 0, 1'b1, 0);
    run(0, 2, 0, 1'b1, 0);
    run(0, 1, 0, 1'b0, 0);
    idle(3);
    // Random mismatch patterns.
    for (int i = 0; i < 6; i++) begin
      run(0, 2, 0, 1'b0, 0);
      idle($urandom_range(1, 4));
    end
    // Saturation with the long run.
    run(1, 1, 0, 1'b0, 0);
    idle(3);

    chk("pending_runs_dut0", q_exp0.size(), 0);
    chk("pending_runs_dut1", q_exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
